// File: rtl/demux_tdm_defs.sv
// Shared constants for the TDM link: FSM state encoding and slot indices.
package demux_tdm_defs;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Increment-with-saturation counter; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/demux_tdm.sv
// 4-slot TDM demultiplexer: sync-aligned slot capture into shadows, atomic
// frame update of d0..d3 on the slot-3 sample, alignment error reporting.
module demux_tdm
  import demux_tdm_defs::*;
#(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] y_in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state, state_nxt;
  logic [1:0]       slot_nxt;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic             sh0_we, sh1_we, sh2_we, load, err;

  // next-state, slot advance and capture strobes
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    sh0_we    = 1'b0;
    sh1_we    = 1'b0;
    sh2_we    = 1'b0;
    load      = 1'b0;
    err       = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            sh0_we    = 1'b1;
            slot_nxt  = SLOT1;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sync) begin
            // sync anywhere but slot 0 re-aligns onto the new frame
            err      = (slot != SLOT0);
            sh0_we   = 1'b1;
            slot_nxt = SLOT1;
          end else begin
            unique case (slot)
              SLOT0: begin
                err       = 1'b1;
                state_nxt = HUNT;
                slot_nxt  = SLOT0;
              end
              SLOT1: begin
                sh1_we   = 1'b1;
                slot_nxt = SLOT2;
              end
              SLOT2: begin
                sh2_we   = 1'b1;
                slot_nxt = SLOT3;
              end
              SLOT3: begin
                load     = 1'b1;
                slot_nxt = SLOT0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // state, slot and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= SLOT0;
      sh0   <= '0;
      sh1   <= '0;
      sh2   <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      if (sh0_we) sh0 <= y_in;
      if (sh1_we) sh1 <= y_in;
      if (sh2_we) sh2 <= y_in;
    end
  end

  // output frame registers and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= load;
      sync_err    <= err;
      if (load) begin
        d0 <= sh0;
        d1 <= sh1;
        d2 <= sh2;
        d3 <= y_in;
      end
    end
  end

  assign locked = (state == LOCK);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err),
    .cnt   (err_cnt)
  );

endmodule

// File: doc/demux_tdm.md
# demux_tdm

Time-division demultiplexer: the receiving end of the 4:1 mux link. It takes one serial data line, carrying four time slots per frame (D0..D3, selected in order S1S0 = 00, 01, 10, 11), and rebuilds the four channels as registered parallel outputs. Frame alignment comes from a sync strobe that marks slot 0. A complete frame is presented atomically with a one-cycle valid pulse. Alignment errors are reported and counted.

## Interface
- `WIDTH`, default 1: bits per slot (data width of each channel).
- `ERR_W`, default 8: width of the saturating error counter.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `y_in` input WIDTH: serial data line, sampled only when `in_valid`=1.
- `in_valid` input 1: the current `y_in` is one slot sample.
- `sync` input 1: qualified by `in_valid`; marks the current sample as slot 0.
- `d0`, `d1`, `d2`, `d3` output WIDTH each: last complete frame, channels 0..3.
- `slot` output 2: index the next valid sample will be assigned (S1S0 equivalent).
- `locked` output 1: 1 while in state LOCK.
- `frame_valid` output 1: one-cycle pulse when `d0..d3` update.
- `sync_err` output 1: one-cycle pulse on an alignment error.
- `err_cnt` output ERR_W: count of `sync_err` pulses, saturating at all-ones.

## Operation
- **States.**
  - HUNT: waiting for alignment.
  - LOCK: aligned, capturing slots in order.
- **Reset (`rst_n`=0, immediate).**
  - State is HUNT.
  - `slot`, `d0..d3`, the shadow registers, `locked`, `frame_valid`, `sync_err` and `err_cnt` are all 0.
- **In HUNT.**
  - Samples without `sync` are discarded. No error is raised.
  - `in_valid`&`sync`: store `y_in` as shadow0, set `slot`=1, go to LOCK.
- **In LOCK, `in_valid`=1.**
  - Slot 0 expected and `sync`=1: store shadow0, `slot`=1.
  - Slot 0 expected and `sync`=0: pulse `sync_err`, discard the sample and any partial frame, go to HUNT, `slot`=0.
  - Slot 1 or 2 expected and `sync`=0: store into shadow1 or shadow2, increment `slot`.
  - Slot 3 expected and `sync`=0:
    - `d0..d2` load from shadow0..shadow2 and `d3` loads `y_in`, all on the same edge.
    - `frame_valid`=1 for that cycle.
    - `slot` wraps to 0. Stay in LOCK.
  - Slot 1, 2 or 3 expected and `sync`=1 (early sync):
    - Pulse `sync_err` and drop the partial frame.
    - Store `y_in` as shadow0, `slot`=1, stay in LOCK (re-align on the new frame).
- **`in_valid`=0.** No state, slot or shadow change. The gap may be any length, including mid-frame.
- **Outputs.** `d0..d3` change only on a `frame_valid` edge and hold otherwise. A partial frame never reaches `d0..d3`.
- **`err_cnt`.** Increments by 1 on each `sync_err` and holds at 2^ERR_W−1.
- **`sync` with `in_valid`=0.** Ignored.

## Timing
- All outputs are registered. There is no combinational input→output path.
- **Latency.** The slot-3 sample is taken on edge N. On edge N, `d0..d3` update and `frame_valid` goes high. `frame_valid` is high for cycle N only.
- **Minimum frame time.** 4 cycles, with `in_valid` held at 1. Back-to-back frames then give `frame_valid` on every 4th cycle.
- **`sync_err` timing.** Asserted for the cycle after the offending sample edge. `err_cnt` updates on the same edge.
- **Reset mid-frame.** The partial frame is lost. The first frame after reset needs a fresh `sync`.
- **Saturation.** At `err_cnt`=all-ones, further errors still pulse `sync_err`, but the count does not change.

## Structure
- **Shared include/package `demux_tdm_defs`.**
  - State encoding: HUNT=1'b0, LOCK=1'b1.
  - Slot constants: SLOT0..SLOT3 = 2'd0..2'd3.
  - These constants are also used by the mux-side bench.
- **Sub-module `sat_counter`.**
  - Parameterised-width increment-with-saturation, used for `err_cnt`.
- **Main module contains:**
  - the FSM;
  - the slot counter;
  - the three shadow registers;
  - the output registers.

## Test plan
- **Clean frames.**
  - Stimulus: `WIDTH`=1, reset, then `in_valid`=1 continuously with `sync` on slot 0, data 1,0,1,1 repeated twice.
  - Required: `frame_valid` at cycles 4 and 8, `d0..d3`=1,0,1,1, `sync_err`=0, `err_cnt`=0.
- **Gaps.**
  - Stimulus: `WIDTH`=4, frame A,B,C,D with `in_valid`=0 gaps of 3 cycles between samples.
  - Required: a single `frame_valid`, `d0..d3`=A,B,C,D, outputs unchanged before it.
- **Early sync.**
  - Stimulus: `sync` on slot 0, then 2 samples, then `sync` again with 4 samples 5,6,7,8 (`WIDTH`=4).
  - Required: one `sync_err`, `err_cnt`=1, `locked`=1 throughout, then `frame_valid` with `d0..d3`=5,6,7,8.
- **Missing sync.**
  - Stimulus: a good frame, then 4 samples without `sync`.
  - Required: `sync_err` on the first of those samples, `locked`=0, `slot`=0, `d0..d3` hold the first frame. A later `sync` relocks.
- **Reset mid-frame.**
  - Stimulus: `rst_n`=0 after slot 2.
  - Required: all outputs 0 immediately (asynchronous). The next frame needs `sync` and produces `frame_valid` only after 4 new samples.
- **Saturation.**
  - Stimulus: `ERR_W`=2, 5 consecutive missing-sync errors.
  - Required: `err_cnt` sequence 1,2,3,3,3; `sync_err` pulses 5 times.
